arb_grant_mux: RTL and testbench

- Downstream stage of the fixed-priority request arbiter.
- Takes the arbiter's one-hot grant vector plus per-port data, and moves the granted port's beat into a single registered output channel with valid/ready.
- Returns a per-port acknowledge so each requester can drop or advance its request.
- Optionally locks the selection to one port for a multi-beat packet.

---
 rtl/arb_grant_mux.sv | 152 +++++++++++++++
 tb/tb_arb_grant_mux.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/arb_grant_mux.sv
// Moves the granted port's beat into one registered valid/ready output and acks the requester; 1-cycle latency, full rate under ready.
// Holds the beat and withholds ack while out_ready_i is low. Define ARB_GRANT_MUX_LOCK_EN to lock selection for multi-beat packets.
module arb_grant_mux #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS-1:0]        gnt_i,
  input  logic [NUM_PORTS*DATA_W-1:0] data_i,
  input  logic [NUM_PORTS-1:0]        last_i,
  output logic [NUM_PORTS-1:0]        ack_o,
  output logic                        lock_o,
  output logic                        out_valid_o,
  output logic [DATA_W-1:0]           out_data_o,
  output logic                        out_last_o,
  output logic [PW-1:0]               out_port_o,
  input  logic                        out_ready_i
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_last_q,  out_last_d;
  logic [PW-1:0]     out_port_q,  out_port_d;

  logic              slot_free;
  logic              gnt_any;
  logic [PW-1:0]     gnt_idx;
  logic              sel_vld;
  logic [PW-1:0]     sel_idx;
  logic              capture;

  // Lowest set grant bit wins, matching port 0 as highest priority.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (gnt_i[i]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(i);
      end
    end
  end

`ifdef ARB_GRANT_MUX_LOCK_EN
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state_q,     state_d;
  logic [PW-1:0] lock_port_q, lock_port_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lock_port_q <= '0;
    end else begin
      state_q     <= state_d;
      lock_port_q <= lock_port_d;
    end
  end

  // Once locked, only the lock port may feed the output; gnt_i is ignored.
  always_comb begin
    sel_vld = gnt_any;
    sel_idx = gnt_idx;
    if (state_q == LOCKED) begin
      sel_vld = req_i[lock_port_q];
      sel_idx = lock_port_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_port_d = lock_port_q;
    case (state_q)
      IDLE: begin
        if (capture && !last_i[sel_idx]) begin
          state_d     = LOCKED;
          lock_port_d = sel_idx;
        end
      end
      LOCKED: begin
        if (capture && last_i[sel_idx]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lock_o = (state_q == LOCKED);
  end
`else
  logic unused_req;

  assign unused_req = ^req_i;

  always_comb begin
    sel_vld = gnt_any;
    sel_idx = gnt_idx;
    lock_o  = 1'b0;
  end
`endif

  assign slot_free = !out_valid_q || out_ready_i;
  // Reset also blocks acks, so no requester advances on a beat that is dropped.
  assign capture   = slot_free && sel_vld && !reset;

  always_comb begin
    ack_o = '0;
    if (capture) begin
      ack_o[sel_idx] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_port_d  = out_port_q;
    if (capture) begin
      out_valid_d = 1'b1;
      out_data_d  = data_i[sel_idx*DATA_W +: DATA_W];
      out_last_d  = last_i[sel_idx];
      out_port_d  = sel_idx;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_port_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_port_q  <= out_port_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign out_port_o  = out_port_q;

endmodule

// File: tb/tb_arb_grant_mux.sv
// Directed bench for arb_grant_mux: reset, streaming, backpressure, multi-bit grant, packet lock, reset mid-packet.
module tb_arb_grant_mux;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int PW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [NP-1:0]  req_i;
  logic [NP-1:0]  gnt_i;
  logic [NP*DW-1:0] data_i;
  logic [NP-1:0]  last_i;
  logic [NP-1:0]  ack_o;
  logic           lock_o;
  logic           out_valid_o;
  logic [DW-1:0]  out_data_o;
  logic           out_last_o;
  logic [PW-1:0]  out_port_o;
  logic           out_ready_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arb_grant_mux #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .gnt_i       (gnt_i),
    .data_i      (data_i),
    .last_i      (last_i),
    .ack_o       (ack_o),
    .lock_o      (lock_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_port_o  (out_port_o),
    .out_ready_i (out_ready_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input logic [DW-1:0] v, input logic l);
    data_i[p*DW +: DW] = v;
    last_i[p]          = l;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs sampled 1 unit later.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    req_i       = '0;
    gnt_i       = 4'b0010;
    data_i      = '0;
    last_i      = '1;
    out_ready_i = 1'b1;
    set_port(1, 8'h21, 1'b1);

    edge_step();
    edge_step();
    #1;
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_ack",   32'(ack_o),       32'h0);
    check("rst_lock",  32'(lock_o),      32'd0);
    check("rst_data",  32'(out_data_o),  32'h0);
    check("rst_port",  32'(out_port_o),  32'd0);

    reset = 1'b0;
    #1;
    check("first_ack", 32'(ack_o), 32'b0010);
    edge_step();
    check("first_valid", 32'(out_valid_o), 32'd1);
    check("first_port",  32'(out_port_o),  32'd1);
    check("first_data",  32'(out_data_o),  32'h21);

    // Streaming from port 2, one beat per cycle.
    gnt_i = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      set_port(2, 8'(8'h10 + k), 1'b1);
      #1;
      check("stream_ack", 32'(ack_o), 32'b0100);
      edge_step();
      check("stream_data",  32'(out_data_o),  32'(8'h10 + k));
      check("stream_valid", 32'(out_valid_o), 32'd1);
      check("stream_port",  32'(out_port_o),  32'd2);
    end

    // Backpressure: hold 0xA5 for three cycles, then drain and reload.
    set_port(2, 8'hA5, 1'b1);
    edge_step();
    check("bp_load", 32'(out_data_o), 32'hA5);
    out_ready_i = 1'b0;
    gnt_i       = 4'b0001;
    set_port(0, 8'h55, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ack", 32'(ack_o), 32'h0);
      edge_step();
      check("bp_hold_data",  32'(out_data_o),  32'hA5);
      check("bp_hold_valid", 32'(out_valid_o), 32'd1);
    end
    out_ready_i = 1'b1;
    #1;
    check("bp_release_ack", 32'(ack_o), 32'b0001);
    edge_step();
    check("bp_next_valid", 32'(out_valid_o), 32'd1);
    check("bp_next_data",  32'(out_data_o),  32'h55);
    check("bp_next_port",  32'(out_port_o),  32'd0);

    // Multi-bit grant: lowest index wins.
    gnt_i = 4'b1010;
    set_port(1, 8'h66, 1'b0);
    set_port(3, 8'h77, 1'b1);
    #1;
    check("multi_ack", 32'(ack_o), 32'b0010);
    gnt_i = 4'b1010;
    set_port(1, 8'h66, 1'b1);
    edge_step();
    check("multi_port", 32'(out_port_o), 32'd1);
    check("multi_data", 32'(out_data_o), 32'h66);
    check("multi_last", 32'(out_last_o), 32'd1);

    // No grant with ready high drains the output.
    gnt_i = 4'b0000;
    #1;
    check("idle_ack", 32'(ack_o), 32'h0);
    edge_step();
    check("idle_valid", 32'(out_valid_o), 32'd0);

    // Port 3 starts a two-beat packet, then the arbiter grants port 0.
    req_i = 4'b1000;
    gnt_i = 4'b1000;
    set_port(3, 8'h30, 1'b0);
    #1;
    check("pkt_first_ack", 32'(ack_o), 32'b1000);
    edge_step();
    check("pkt_first_data", 32'(out_data_o), 32'h30);
    check("pkt_first_last", 32'(out_last_o), 32'd0);
    req_i = 4'b1001;
    gnt_i = 4'b0001;
    set_port(3, 8'h31, 1'b1);
    set_port(0, 8'h05, 1'b1);
    #1;
`ifdef ARB_GRANT_MUX_LOCK_EN
    check("lock_on",   32'(lock_o), 32'd1);
    check("lock_ack3", 32'(ack_o),  32'b1000);
    edge_step();
    check("lock_data",    32'(out_data_o), 32'h31);
    check("lock_port",    32'(out_port_o), 32'd3);
    check("lock_release", 32'(lock_o),     32'd0);
    req_i = 4'b0001;
    #1;
    check("after_lock_ack", 32'(ack_o), 32'b0001);
    edge_step();
    check("after_lock_port", 32'(out_port_o), 32'd0);
    check("after_lock_data", 32'(out_data_o), 32'h05);
`else
    check("nolock_lock", 32'(lock_o), 32'd0);
    check("nolock_ack",  32'(ack_o),  32'b0001);
    edge_step();
    check("nolock_port", 32'(out_port_o), 32'd0);
    check("nolock_data", 32'(out_data_o), 32'h05);
`endif

    // Start another packet on port 3, stall its request, then reset mid-packet.
    req_i = 4'b1000;
    gnt_i = 4'b1000;
    set_port(3, 8'h40, 1'b0);
    edge_step();
    check("mid_valid", 32'(out_valid_o), 32'd1);
    check("mid_data",  32'(out_data_o),  32'h40);
    req_i = 4'b0001;
    gnt_i = 4'b0001;
    #1;
`ifdef ARB_GRANT_MUX_LOCK_EN
    check("bubble_ack",  32'(ack_o),  32'h0);
    check("bubble_lock", 32'(lock_o), 32'd1);
`else
    check("bubble_ack",  32'(ack_o),  32'b0001);
    check("bubble_lock", 32'(lock_o), 32'd0);
`endif
    reset = 1'b1;
    #1;
    check("mid_rst_ack", 32'(ack_o), 32'h0);
    edge_step();
    check("mid_rst_valid", 32'(out_valid_o), 32'd0);
    check("mid_rst_lock",  32'(lock_o),      32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ack", 32'(ack_o), 32'b0001);
    edge_step();
    check("post_rst_port", 32'(out_port_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
